// File: rtl/cellrv32_npu_weight_scheduler_pkg.sv
// Shared types for the NPU weight scheduler: weight instruction record and scheduler FSM states.
// Pure type/constant package; no timing or flow-control behaviour of its own.
package cellrv32_npu_weight_scheduler_pkg;

  typedef struct packed {
    logic [15:0] wei_addr;
    logic [15:0] calc_len;
  } weight_instruction_t;

  localparam int WEIGHT_INSTR_W = $bits(weight_instruction_t);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    WAIT_DONE
  } WEIGHT_SCHED_STATE_t;

endpackage

// File: rtl/cellrv32_npu_instr_fifo.sv
// Generic synchronous FIFO (push/pop/full/empty/count), head visible combinationally, 0 when empty.
// Latency: write visible at head the cycle after push; push ignored when full, pop ignored when empty.
module cellrv32_npu_instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == (AW+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = empty_o ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  // Storage needs no reset: entries are only observed through the count.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/cellrv32_npu_weight_scheduler.sv
// Buffers weight-load instructions and issues one at a time to weight control when a preload slot is free.
// Issue earliest one cycle after push; instr_ready_o drops when the FIFO is full; enable_i low freezes everything.
module cellrv32_npu_weight_scheduler
  import cellrv32_npu_weight_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int PRELOAD_SLOTS = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  weight_instruction_t instr_i,
  input  logic                instr_valid_i,
  output logic                instr_ready_o,
  output weight_instruction_t wc_instr_o,
  output logic                wc_instr_en_o,
  input  logic                wc_busy_i,
  input  logic                wc_resource_busy_i,
  input  logic                activate_i,
  output logic                weights_ready_o,
  output logic [1:0]          loaded_cnt_o,
  output logic                idle_o,
  output logic                err_o
);

  localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0] LP_SLOTS = 3'(PRELOAD_SLOTS);

  WEIGHT_SCHED_STATE_t r_state;
  WEIGHT_SCHED_STATE_t w_state_nxt;
  logic                r_inflight;
  logic [1:0]          r_loaded_cnt;
  logic                r_err;

  logic                w_push;
  logic                w_full;
  logic                w_empty;
  logic [CW-1:0]       w_fifo_count;
  logic [2:0]          w_outstanding;
  logic                w_issue_ok;
  logic                w_load_done;
  logic                w_act_ok;
  logic                w_act_err;

  assign instr_ready_o = (w_fifo_count != CW'(FIFO_DEPTH));
  assign w_push        = instr_valid_i & instr_ready_o & enable_i;

  cellrv32_npu_instr_fifo #(
    .WIDTH (WEIGHT_INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (wc_instr_en_o),
    .data_i  (instr_i),
    .data_o  (wc_instr_o),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_fifo_count)
  );

  assign w_outstanding = {2'b00, r_inflight} + {1'b0, r_loaded_cnt};
  assign w_issue_ok    = ~w_empty & (w_outstanding < LP_SLOTS) & ~wc_busy_i
                       & ~wc_resource_busy_i & enable_i;

  // ARM exists because weight control raises busy one cycle after the strobe.
  always_comb begin
    w_state_nxt   = r_state;
    wc_instr_en_o = 1'b0;
    w_load_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_issue_ok) begin
          wc_instr_en_o = 1'b1;
          w_state_nxt   = ARM;
        end
      end
      ARM: begin
        if (enable_i) w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (enable_i && !wc_resource_busy_i) begin
          w_load_done = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_act_ok  = activate_i & enable_i & (r_loaded_cnt != 2'd0);
  assign w_act_err = activate_i & enable_i & (r_loaded_cnt == 2'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_inflight   <= 1'b0;
      r_loaded_cnt <= 2'd0;
      r_err        <= 1'b0;
    end else if (enable_i) begin
      r_state <= w_state_nxt;
      if (wc_instr_en_o)    r_inflight <= 1'b1;
      else if (w_load_done) r_inflight <= 1'b0;
      // Completion and activate together leave the count unchanged.
      case ({w_load_done, w_act_ok})
        2'b10:   r_loaded_cnt <= r_loaded_cnt + 2'd1;
        2'b01:   r_loaded_cnt <= r_loaded_cnt - 2'd1;
        default: r_loaded_cnt <= r_loaded_cnt;
      endcase
      if (w_act_err) r_err <= 1'b1;
    end
  end

  assign weights_ready_o = (r_loaded_cnt != 2'd0);
  assign loaded_cnt_o    = r_loaded_cnt;
  assign idle_o          = w_empty & (r_state == IDLE) & (r_loaded_cnt == 2'd0);
  assign err_o           = r_err;

  a_loaded_le_slots: assert property (@(posedge clk_i) disable iff (rst_i)
    {1'b0, r_loaded_cnt} <= LP_SLOTS);
  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && w_full));

endmodule

// File: tb/tb_cellrv32_npu_weight_scheduler.sv
// Bench for the weight scheduler: table of single-load vectors plus hand sequences for slot limit,
// FIFO full, activate/err, stall and mid-load reset; issued instructions checked against a queue.
module tb_cellrv32_npu_weight_scheduler;
  import cellrv32_npu_weight_scheduler_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_i = 1'b1;
  logic                enable_i = 1'b1;
  weight_instruction_t instr_i = '0;
  logic                instr_valid_i = 1'b0;
  logic                instr_ready_o;
  weight_instruction_t wc_instr_o;
  logic                wc_instr_en_o;
  logic                wc_busy_i;
  logic                wc_resource_busy_i;
  logic                activate_i = 1'b0;
  logic                weights_ready_o;
  logic [1:0]          loaded_cnt_o;
  logic                idle_o;
  logic                err_o;

  weight_instruction_t i2_instr = '0;
  logic                i2_vld = 1'b0;
  logic                i2_act = 1'b0;
  logic                o2_ready, o2_en, o2_wr, o2_idle, o2_err;
  weight_instruction_t o2_instr;
  logic [1:0]          o2_loaded;
  logic                wc2_busy;

  cellrv32_npu_weight_scheduler dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
    .instr_i(instr_i), .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .wc_instr_o(wc_instr_o), .wc_instr_en_o(wc_instr_en_o),
    .wc_busy_i(wc_busy_i), .wc_resource_busy_i(wc_resource_busy_i),
    .activate_i(activate_i), .weights_ready_o(weights_ready_o),
    .loaded_cnt_o(loaded_cnt_o), .idle_o(idle_o), .err_o(err_o)
  );

  cellrv32_npu_weight_scheduler #(.FIFO_DEPTH(4), .PRELOAD_SLOTS(2)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
    .instr_i(i2_instr), .instr_valid_i(i2_vld), .instr_ready_o(o2_ready),
    .wc_instr_o(o2_instr), .wc_instr_en_o(o2_en),
    .wc_busy_i(wc2_busy), .wc_resource_busy_i(wc2_busy),
    .activate_i(i2_act), .weights_ready_o(o2_wr),
    .loaded_cnt_o(o2_loaded), .idle_o(o2_idle), .err_o(o2_err)
  );

  // Weight control model: busy rises the cycle after the strobe and lasts calc_len+3 cycles.
  int m_cnt = 0;
  int m2_cnt = 0;
  always @(posedge clk) begin
    if (rst_i) m_cnt <= 0;
    else if (wc_instr_en_o) m_cnt <= int'(wc_instr_o.calc_len) + 3;
    else if (m_cnt > 0) m_cnt <= m_cnt - 1;
    if (rst_i) m2_cnt <= 0;
    else if (o2_en) m2_cnt <= int'(o2_instr.calc_len) + 3;
    else if (m2_cnt > 0) m2_cnt <= m2_cnt - 1;
  end
  assign wc_busy_i          = (m_cnt != 0);
  assign wc_resource_busy_i = (m_cnt != 0);
  assign wc2_busy           = (m2_cnt != 0);

  int n_checks = 0;
  int n_errors = 0;
  int n_issue = 0;
  int n_issue2 = 0;
  int n_act = 0;
  weight_instruction_t exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic fail_to(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait expired, required event not seen at %0t", nm, $time);
  endtask

  // Scoreboard: every issue strobe must present the oldest accepted instruction.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (wc_instr_en_o) begin
        n_issue++;
        if (exp_q.size() == 0) fail_to("issue_expected_in_queue");
        else check("issue_instr", 32'(wc_instr_o), 32'(exp_q.pop_front()));
      end
      if (o2_en) n_issue2++;
    end
  end

  task automatic do_reset();
    rst_i = 1'b1; enable_i = 1'b1; instr_valid_i = 1'b0; activate_i = 1'b0;
    i2_vld = 1'b0; i2_act = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    exp_q.delete();
    n_issue = 0; n_issue2 = 0; n_act = 0;
    check("rst_ready",   32'(instr_ready_o),   32'd1);
    check("rst_en",      32'(wc_instr_en_o),   32'd0);
    check("rst_wready",  32'(weights_ready_o), 32'd0);
    check("rst_idle",    32'(idle_o),          32'd1);
    check("rst_instr",   32'(wc_instr_o),      32'd0);
    check("rst_loaded",  32'(loaded_cnt_o),    32'd0);
    check("rst_err",     32'(err_o),           32'd0);
  endtask

  task automatic push(input weight_instruction_t ins, input int budget);
    int w = 0;
    instr_i = ins;
    instr_valid_i = 1'b1;
    while (!instr_ready_o) begin
      @(negedge clk);
      w++;
      if (w > budget) begin
        fail_to("push_accept");
        instr_valid_i = 1'b0;
        return;
      end
    end
    @(posedge clk);
    exp_q.push_back(ins);
    @(negedge clk);
    instr_valid_i = 1'b0;
  endtask

  task automatic pulse_act();
    activate_i = 1'b1;
    n_act++;
    @(negedge clk);
    activate_i = 1'b0;
  endtask

  // Activates every loaded tile until `target` issues have happened and the block is idle.
  task automatic drain(input int target, input int budget);
    int c = 0;
    while (!(n_issue == target && idle_o)) begin
      activate_i = (loaded_cnt_o != 2'd0);
      if (activate_i) n_act++;
      @(negedge clk);
      c++;
      if (c > budget) begin
        fail_to("drain");
        break;
      end
    end
    activate_i = 1'b0;
  endtask

  typedef struct {
    weight_instruction_t ins;
    int                  n_act;
    int                  exp_lat;
    logic [1:0]          exp_cnt;
    logic                exp_err;
    logic                exp_idle;
  } vec_t;
  vec_t tv[4];

  task automatic set_vec(input int i, input logic [15:0] a, input logic [15:0] l, input int na,
                         input int lat, input logic [1:0] c, input logic e, input logic id);
    tv[i].ins.wei_addr = a;
    tv[i].ins.calc_len = l;
    tv[i].n_act = na;
    tv[i].exp_lat = lat;
    tv[i].exp_cnt = c;
    tv[i].exp_err = e;
    tv[i].exp_idle = id;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int c;
    weight_instruction_t w;

    // latency = busy duration (calc_len+3) + ARM cycle + completion cycle
    set_vec(0, 16'h0040, 16'd14, 0, 19, 2'd1, 1'b0, 1'b0);
    set_vec(1, 16'h1234, 16'd2,  1,  7, 2'd0, 1'b0, 1'b1);
    set_vec(2, 16'hBEEF, 16'd5,  2, 10, 2'd0, 1'b1, 1'b1);
    set_vec(3, 16'h0000, 16'd0,  1,  5, 2'd0, 1'b0, 1'b1);

    for (int r = 0; r < 4; r++) begin
      do_reset();
      push(tv[r].ins, 10);
      check("t_issue_strobe", 32'(wc_instr_en_o), 32'd1);
      check("t_issue_addr", 32'(wc_instr_o.wei_addr), 32'(tv[r].ins.wei_addr));
      lat = 0;
      while (loaded_cnt_o == 2'd0 && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      check("t_load_latency", 32'(lat), 32'(tv[r].exp_lat));
      check("t_loaded", 32'(loaded_cnt_o), 32'd1);
      check("t_wready", 32'(weights_ready_o), 32'd1);
      check("t_idle_loaded", 32'(idle_o), 32'd0);
      check("t_one_issue", 32'(n_issue), 32'd1);
      for (int k = 0; k < tv[r].n_act; k++) pulse_act();
      check("t_final_cnt", 32'(loaded_cnt_o), 32'(tv[r].exp_cnt));
      check("t_final_err", 32'(err_o), 32'(tv[r].exp_err));
      check("t_final_idle", 32'(idle_o), 32'(tv[r].exp_idle));
      check("t_final_wready", 32'(weights_ready_o), 32'(tv[r].exp_cnt != 2'd0));
    end

    // One preload slot: three queued instructions, one issue until an activate frees the slot.
    do_reset();
    for (int k = 0; k < 3; k++) push('{wei_addr: 16'h0100 + 16'(k), calc_len: 16'd3}, 10);
    repeat (40) @(negedge clk);
    check("slot_one_issue", 32'(n_issue), 32'd1);
    check("slot_loaded", 32'(loaded_cnt_o), 32'd1);
    check("slot_ready", 32'(instr_ready_o), 32'd1);
    pulse_act();
    check("slot_reissue_next", 32'(wc_instr_en_o), 32'd1);
    drain(3, 300);
    check("slot_total_issues", 32'(n_issue), 32'd3);
    check("slot_total_acts", 32'(n_act), 32'd3);
    check("slot_queue_empty", 32'(exp_q.size()), 32'd0);

    // FIFO full: first push issues, four more fill it; a sixth valid must wait and not be lost.
    do_reset();
    for (int k = 0; k < 5; k++) push('{wei_addr: 16'h0200 + 16'(k), calc_len: 16'd2}, 10);
    check("full_not_ready", 32'(instr_ready_o), 32'd0);
    w = '{wei_addr: 16'h02FF, calc_len: 16'd1};
    fork
      push(w, 300);
      begin
        repeat (5) @(negedge clk);
        check("full_held", 32'(instr_ready_o), 32'd0);
        check("full_issues", 32'(n_issue), 32'd1);
        drain(6, 600);
      end
    join
    check("full_all_issued", 32'(n_issue), 32'd6);
    check("full_queue_empty", 32'(exp_q.size()), 32'd0);

    // Two slots: completion of the second tile coincides with activate of the first.
    do_reset();
    i2_instr = '{wei_addr: 16'h0300, calc_len: 16'd3};
    i2_vld = 1'b1;
    @(negedge clk);
    check("s2_issue_strobe", 32'(o2_en), 32'd1);
    check("s2_issue_instr", 32'(o2_instr), 32'h0300_0003);
    check("s2_ready", 32'(o2_ready), 32'd1);
    i2_instr = '{wei_addr: 16'h0301, calc_len: 16'd3};
    @(negedge clk);
    i2_vld = 1'b0;
    c = 0;
    while (n_issue2 < 2 && c < 200) begin @(negedge clk); c++; end
    if (c >= 200) fail_to("s2_second_issue");
    c = 0;
    while (!wc2_busy && c < 50) begin @(negedge clk); c++; end
    c = 0;
    while (wc2_busy && c < 50) begin @(negedge clk); c++; end
    if (c >= 50) fail_to("s2_busy_fall");
    check("s2_first_loaded", 32'(o2_loaded), 32'd1);
    i2_act = 1'b1;
    @(negedge clk);
    i2_act = 1'b0;
    check("s2_net_zero_cnt", 32'(o2_loaded), 32'd1);
    check("s2_net_zero_wready", 32'(o2_wr), 32'd1);
    check("s2_no_err", 32'(o2_err), 32'd0);
    i2_act = 1'b1;
    @(negedge clk);
    i2_act = 1'b0;
    check("s2_drained", 32'(o2_loaded), 32'd0);
    check("s2_idle", 32'(o2_idle), 32'd1);

    // Activate with nothing loaded: sticky error until reset.
    do_reset();
    pulse_act();
    check("err_set", 32'(err_o), 32'd1);
    check("err_cnt_zero", 32'(loaded_cnt_o), 32'd0);
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(err_o), 32'd1);
    do_reset();

    // Stall across the busy-fall edge: nothing moves, activate ignored, load completes on resume.
    push('{wei_addr: 16'h0080, calc_len: 16'd4}, 10);
    c = 0;
    while (m_cnt != 1 && c < 50) begin @(negedge clk); c++; end
    if (c >= 50) fail_to("stall_reach_fall");
    enable_i = 1'b0;
    activate_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_loaded", 32'(loaded_cnt_o), 32'd0);
      check("stall_no_issue", 32'(wc_instr_en_o), 32'd0);
      check("stall_no_err", 32'(err_o), 32'd0);
    end
    enable_i = 1'b1;
    activate_i = 1'b0;
    @(negedge clk);
    check("stall_resume_load", 32'(loaded_cnt_o), 32'd1);

    // Reset while a load is in progress with another instruction queued.
    do_reset();
    push('{wei_addr: 16'h0400, calc_len: 16'd6}, 10);
    push('{wei_addr: 16'h0401, calc_len: 16'd6}, 10);
    c = 0;
    while (!wc_busy_i && c < 20) begin @(negedge clk); c++; end
    repeat (3) @(negedge clk);
    do_reset();
    repeat (30) @(negedge clk);
    check("mid_rst_no_issue", 32'(n_issue), 32'd0);
    check("mid_rst_idle", 32'(idle_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
